btb_assoc: RTL and testbench

Parametrised set-associative branch target buffer with per-entry saturating direction counters, a successor to the direct-mapped 16-bit BTB. It sits in the fetch stage. Each cycle it returns a combinational next-PC prediction for the current fetch PC. It is trained from the execute stage with resolved branch outcomes. Unlike the direct-mapped version, it supports configurable address width, set count and associativity, LRU replacement, taken/not-taken hysteresis and a synchronous flush.

---
 rtl/btb_assoc_pkg.sv | 43 ++++
 rtl/btb_assoc_if.sv | 22 ++
 rtl/btb_assoc_way.sv | 61 ++++++
 rtl/btb_assoc.sv | 120 ++++++++++++
 tb/tb_btb_assoc.sv | 121 ++++++++++++
 5 files changed

// File: rtl/btb_assoc_pkg.sv
// Shared types, geometry helpers and counter arithmetic for the set-associative BTB.
package btb_pkg;

    // Default geometry; modules take their own parameters and derive with the helpers below.
    localparam int DEF_PC_W  = 16;
    localparam int DEF_IDX_W = 8;
    localparam int DEF_CTR_W = 2;

    localparam int TAG_W = DEF_PC_W - 2 - DEF_IDX_W;
    localparam int SETS  = 1 << DEF_IDX_W;

    // Weakly taken: MSB set, rest clear.
    localparam logic [DEF_CTR_W-1:0] CTR_INIT = DEF_CTR_W'(1 << (DEF_CTR_W - 1));

    // One way's worth of state for one set at the default geometry.
    typedef struct packed {
        logic                   valid;
        logic [TAG_W-1:0]       tag;
        logic [DEF_PC_W-3:0]    target;
        logic [DEF_CTR_W-1:0]   ctr;
    } btb_entry_t;

    function automatic int tag_w(input int pc_w, input int idx_w);
        return pc_w - 2 - idx_w;
    endfunction

    function automatic logic [31:0] ctr_init(input int w);
        return 32'd1 << (w - 1);
    endfunction

    // Saturating increment of a w-bit counter carried in 32 bits.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max_v;
        max_v = (32'd1 << w) - 32'd1;
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

    // Saturating decrement, floored at zero.
    function automatic logic [31:0] sat_dec(input logic [31:0] v, input int w);
        return (v == 32'd0) ? 32'd0 : v - 32'd1;
    endfunction

endpackage

// File: rtl/btb_assoc_if.sv
// Fetch lookup and execute training bus of the BTB.
interface btb_assoc_if #(parameter int PC_W = 16);
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] npc_predict;
    logic            hit;
    logic            pred_taken;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic [PC_W-1:0] upd_target;
    logic            upd_taken;
    logic            flush;

    modport master (
        output pc, upd_valid, upd_pc, upd_target, upd_taken, flush,
        input  npc_predict, hit, pred_taken
    );

    modport slave (
        input  pc, upd_valid, upd_pc, upd_target, upd_taken, flush,
        output npc_predict, hit, pred_taken
    );
endinterface

// File: rtl/btb_assoc_way.sv
// One BTB way: tag/target/ctr storage, valid bits, a fetch-side and an update-side read port.
module btb_way
    import btb_pkg::*;
#(
    parameter int PC_W  = 16,
    parameter int IDX_W = 8,
    parameter int CTR_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    // fetch lookup
    input  logic [IDX_W-1:0]      lk_idx,
    input  logic [PC_W-IDX_W-3:0] lk_tag,
    output logic                  lk_hit,
    output logic [PC_W-3:0]       lk_target,
    output logic [CTR_W-1:0]      lk_ctr,
    // update probe; the write goes to the same index/tag
    input  logic [IDX_W-1:0]      up_idx,
    input  logic [PC_W-IDX_W-3:0] up_tag,
    output logic                  up_hit,
    output logic                  up_valid,
    output logic [PC_W-3:0]       up_target,
    output logic [CTR_W-1:0]      up_ctr,
    input  logic                  we,
    input  logic [PC_W-3:0]       wr_target,
    input  logic [CTR_W-1:0]      wr_ctr
);
    localparam int TW = tag_w(PC_W, IDX_W);
    localparam int NS = 1 << IDX_W;

    logic [TW-1:0]     tag_mem    [NS];
    logic [PC_W-3:0]   target_mem [NS];
    logic [CTR_W-1:0]  ctr_mem    [NS];
    logic [NS-1:0]     valid;

    assign lk_hit    = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);
    assign lk_target = target_mem[lk_idx];
    assign lk_ctr    = ctr_mem[lk_idx];

    assign up_valid  = valid[up_idx];
    assign up_hit    = valid[up_idx] && (tag_mem[up_idx] == up_tag);
    assign up_target = target_mem[up_idx];
    assign up_ctr    = ctr_mem[up_idx];

    // Payload arrays carry no reset; stale contents are masked by valid.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[up_idx]    <= up_tag;
            target_mem[up_idx] <= wr_target;
            ctr_mem[up_idx]    <= wr_ctr;
        end
    end

    // Valid bits: async clear on reset, sync clear on flush, set on write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        valid <= '0;
        else if (flush) valid <= '0;
        else if (we)    valid[up_idx] <= 1'b1;
    end
endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB: way select, LRU victim choice, training control and next-PC mux.
module btb_assoc
    import btb_pkg::*;
#(
    parameter int PC_W  = 16,
    parameter int IDX_W = 8,
    parameter int WAYS  = 2,
    parameter int CTR_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    btb_assoc_if.slave  bus
);
    localparam int TW = tag_w(PC_W, IDX_W);
    localparam int NS = 1 << IDX_W;
    localparam logic [CTR_W-1:0] INIT_CTR = CTR_W'(ctr_init(CTR_W));

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TW-1:0]    lk_tag, up_tag;

    logic [WAYS-1:0]                lk_hit, up_hit, up_valid, we;
    logic [WAYS-1:0][PC_W-3:0]      lk_target, up_target;
    logic [WAYS-1:0][CTR_W-1:0]     lk_ctr, up_ctr;

    logic             hit_any, up_any, up_way, victim, wr_way, wr_en;
    logic [PC_W-3:0]  sel_target, up_tgt_old, wr_target;
    logic [CTR_W-1:0] sel_ctr, up_ctr_old, wr_ctr;

    assign lk_idx = bus.pc[IDX_W+1:2];
    assign lk_tag = bus.pc[PC_W-1:IDX_W+2];
    assign up_idx = bus.upd_pc[IDX_W+1:2];
    assign up_tag = bus.upd_pc[PC_W-1:IDX_W+2];

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        btb_way #(.PC_W(PC_W), .IDX_W(IDX_W), .CTR_W(CTR_W)) u_way (
            .clk       (clk),
            .rst       (rst),
            .flush     (bus.flush),
            .lk_idx    (lk_idx),
            .lk_tag    (lk_tag),
            .lk_hit    (lk_hit[w]),
            .lk_target (lk_target[w]),
            .lk_ctr    (lk_ctr[w]),
            .up_idx    (up_idx),
            .up_tag    (up_tag),
            .up_hit    (up_hit[w]),
            .up_valid  (up_valid[w]),
            .up_target (up_target[w]),
            .up_ctr    (up_ctr[w]),
            .we        (we[w]),
            .wr_target (wr_target),
            .wr_ctr    (wr_ctr)
        );
    end

    // Fetch-side way select; tags are unique within a set so at most one way matches.
    always_comb begin
        hit_any    = 1'b0;
        sel_target = '0;
        sel_ctr    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (lk_hit[w]) begin
                hit_any    = 1'b1;
                sel_target = lk_target[w];
                sel_ctr    = lk_ctr[w];
            end
        end
    end

    assign bus.hit         = hit_any;
    assign bus.pred_taken  = hit_any && sel_ctr[CTR_W-1];
    assign bus.npc_predict = bus.pred_taken ? {sel_target, 2'b00} : bus.pc + PC_W'(4);

    // Update-side way select against the pre-update contents.
    always_comb begin
        up_any     = 1'b0;
        up_way     = 1'b0;
        up_tgt_old = '0;
        up_ctr_old = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (up_hit[w]) begin
                up_any     = 1'b1;
                up_way     = 1'(w);
                up_tgt_old = up_target[w];
                up_ctr_old = up_ctr[w];
            end
        end
    end

    // Victim choice: first invalid way, otherwise the LRU way.
    if (WAYS == 2) begin : g_lru
        logic [NS-1:0] lru;

        assign victim = !up_valid[0] ? 1'b0 : (!up_valid[1] ? 1'b1 : lru[up_idx]);

        // LRU points away from the way just touched; flush and reset clear it.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)            lru <= '0;
            else if (bus.flush) lru <= '0;
            else if (wr_en)     lru[up_idx] <= ~wr_way;
        end
    end else begin : g_nolru
        assign victim = 1'b0;
    end

    // Write control: hits always train, misses allocate only when taken; flush drops the update.
    always_comb begin
        wr_en  = bus.upd_valid && !bus.flush && (up_any || bus.upd_taken);
        wr_way = up_any ? up_way : victim;
        if (!up_any)
            wr_ctr = INIT_CTR;
        else if (bus.upd_taken)
            wr_ctr = CTR_W'(sat_inc(32'(up_ctr_old), CTR_W));
        else
            wr_ctr = CTR_W'(sat_dec(32'(up_ctr_old), CTR_W));
        wr_target = (up_any && !bus.upd_taken) ? up_tgt_old : bus.upd_target[PC_W-1:2];
        for (int w = 0; w < WAYS; w++)
            we[w] = wr_en && (wr_way == 1'(w));
    end
endmodule

// File: tb/tb_btb_assoc.sv
// Directed test of btb_assoc at default geometry with hand-computed expectations.
module tb_btb_assoc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    btb_assoc_if #(.PC_W(16)) bus ();

    btb_assoc #(.PC_W(16), .IDX_W(8), .WAYS(2), .CTR_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one training update across one rising edge; returns at the following falling edge.
    task automatic upd(input logic [15:0] p, input logic [15:0] t, input logic tk);
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = p;
        bus.upd_target = t;
        bus.upd_taken  = tk;
        @(posedge clk);
        @(negedge clk);
        bus.upd_valid  = 1'b0;
    endtask

    // Combinational lookup, checked after settling.
    task automatic look(input string tag, input logic [15:0] p, input logic h,
                        input logic pt, input logic [15:0] npc);
        bus.pc = p;
        #1;
        check({tag, ".hit"}, 32'(bus.hit), 32'(h));
        check({tag, ".pt"},  32'(bus.pred_taken), 32'(pt));
        check({tag, ".npc"}, 32'(bus.npc_predict), 32'(npc));
    endtask

    initial begin
        bus.pc = 16'h0; bus.upd_valid = 1'b0; bus.upd_pc = 16'h0;
        bus.upd_target = 16'h0; bus.upd_taken = 1'b0; bus.flush = 1'b0;

        // Reset held: nothing hits, fall-through prediction.
        @(negedge clk);
        look("rst_hold", 16'h0100, 1'b0, 1'b0, 16'h0104);
        @(negedge clk);
        rst = 1'b0;
        look("cold", 16'h0100, 1'b0, 1'b0, 16'h0104);
        look("wrap", 16'hFFFC, 1'b0, 1'b0, 16'h0000);

        // Lookup in the same cycle as the first taken update sees the old contents.
        bus.pc = 16'h0100;
        bus.upd_valid = 1'b1; bus.upd_pc = 16'h0100;
        bus.upd_target = 16'h0200; bus.upd_taken = 1'b1;
        #1;
        check("same_cyc.hit", 32'(bus.hit), 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.upd_valid = 1'b0;
        look("alloc", 16'h0100, 1'b1, 1'b1, 16'h0200);          // ctr 10

        // Hysteresis and saturation.
        upd(16'h0100, 16'h0200, 1'b0);                           // 10 -> 01
        look("nt1", 16'h0100, 1'b1, 1'b0, 16'h0104);
        upd(16'h0100, 16'h0200, 1'b1);                           // 01 -> 10
        upd(16'h0100, 16'h0200, 1'b1);                           // 10 -> 11
        upd(16'h0100, 16'h0200, 1'b1);                           // stays 11
        look("sat", 16'h0100, 1'b1, 1'b1, 16'h0200);
        upd(16'h0100, 16'h0200, 1'b0);                           // 11 -> 10
        look("hyst", 16'h0100, 1'b1, 1'b1, 16'h0200);
        upd(16'h0100, 16'h0200, 1'b0);                           // 10 -> 01, proves no wrap at 11
        look("hyst2", 16'h0100, 1'b1, 1'b0, 16'h0104);
        upd(16'h0100, 16'h0200, 1'b1);                           // 01 -> 10, LRU -> way1

        // Set 0x40: 0x0100 in way0, 0x0500 allocates into empty way1.
        upd(16'h0500, 16'h0600, 1'b1);                           // LRU -> way0
        look("w0", 16'h0100, 1'b1, 1'b1, 16'h0200);
        look("w1", 16'h0500, 1'b1, 1'b1, 16'h0600);
        upd(16'h0100, 16'h0200, 1'b1);                           // touch way0, LRU -> way1
        upd(16'h0900, 16'h0A00, 1'b1);                           // evicts 0x0500
        look("evict", 16'h0500, 1'b0, 1'b0, 16'h0504);
        look("retain", 16'h0100, 1'b1, 1'b1, 16'h0200);
        look("new", 16'h0900, 1'b1, 1'b1, 16'h0A00);

        // Miss not-taken changes nothing.
        upd(16'h1100, 16'h1200, 1'b0);
        look("miss_nt", 16'h1100, 1'b0, 1'b0, 16'h1104);
        look("miss_nt_keep", 16'h0900, 1'b1, 1'b1, 16'h0A00);

        // Flush wins over a same-edge update.
        bus.flush = 1'b1;
        upd(16'h0300, 16'h0400, 1'b1);
        bus.flush = 1'b0;
        look("fl_new", 16'h0300, 1'b0, 1'b0, 16'h0304);
        look("fl_old", 16'h0100, 1'b0, 1'b0, 16'h0104);
        look("fl_old2", 16'h0900, 1'b0, 1'b0, 16'h0904);

        // Reallocate after flush, then async reset mid-cycle.
        upd(16'h0100, 16'h0200, 1'b1);
        look("realloc", 16'h0100, 1'b1, 1'b1, 16'h0200);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst.hit", 32'(bus.hit), 32'd0);
        check("async_rst.npc", 32'(bus.npc_predict), 32'h0104);
        @(negedge clk);
        rst = 1'b0;
        look("post_rst", 16'h0100, 1'b0, 1'b0, 16'h0104);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
